// File: rtl/conv_feeder_pkg.sv
// Shared types and constants for the convolution feeder (package conv_pkg).
// Kernel weight counts, the FSM state encoding and the default pixel width live here.
package conv_pkg;

  localparam int DEF_DW = 16;
  localparam int NW0    = 9;
  localparam int NW1    = 90;
  localparam int WV_W   = 90;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Index of the final weight bit for the selected kernel mode.
  function automatic logic [6:0] last_wbit(input logic mode);
    return mode ? 7'(NW1 - 1) : 7'(NW0 - 1);
  endfunction

endpackage

// File: rtl/conv_feeder_if.sv
// Bus between the feeder, the feature buffer and the convolution engine.
// master is the feeder's view; slave is the environment's view.
interface conv_feeder_if #(parameter int DW = conv_pkg::DEF_DW) ();

  logic                       go;
  logic                       mode;
  logic [conv_pkg::WV_W-1:0]  wvec;
  logic                       rd_en;
  logic [15:0]                rd_addr;
  logic [DW-1:0]              rd_data;
  logic                       conv_start;
  logic [DW-1:0]              conv_din;
  logic                       conv_state;
  logic                       conv_weight_en;
  logic                       conv_weight;
  logic                       conv_done;
  logic                       busy;
  logic                       job_done;

  modport master (
    input  go, mode, wvec, rd_data, conv_done,
    output rd_en, rd_addr, conv_start, conv_din, conv_state,
           conv_weight_en, conv_weight, busy, job_done
  );

  modport slave (
    output go, mode, wvec, rd_data, conv_done,
    input  rd_en, rd_addr, conv_start, conv_din, conv_state,
           conv_weight_en, conv_weight, busy, job_done
  );

endinterface

// File: rtl/conv_feeder_addr_gen.sv
// Row/column walk over the feature map and row-major pixel address generation.
// With CONV_FEEDER_PAD_EN the walk covers a 1-pixel zero border that issues no reads.
module conv_feeder_addr_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  output logic        o_issue,
  output logic        o_border,
  output logic        o_last,
  output logic [15:0] o_addr
);

`ifdef CONV_FEEDER_PAD_EN
  localparam int COLS = IMG_W + 2;
  localparam int ROWS = IMG_H + 2;
`else
  localparam int COLS = IMG_W;
  localparam int ROWS = IMG_H;
`endif

  localparam logic [15:0] LAST_COL  = 16'(COLS - 1);
  localparam logic [15:0] LAST_ROW  = 16'(ROWS - 1);
  localparam logic [15:0] LAST_ADDR = 16'(IMG_W * IMG_H - 1);

  logic [15:0] r_row;
  logic [15:0] r_col;
  logic [15:0] r_addr;
  logic        r_fin;
  logic        w_issue;
  logic        w_at_end;
  logic        w_border;

  assign w_issue  = i_en & ~r_fin;
  assign w_at_end = (r_row == LAST_ROW) && (r_col == LAST_COL);

`ifdef CONV_FEEDER_PAD_EN
  assign w_border = (r_row == 16'd0) || (r_row == LAST_ROW) ||
                    (r_col == 16'd0) || (r_col == LAST_COL);
`else
  assign w_border = 1'b0;
`endif

  // Walk position advances once per issued sample; r_fin stops the walk after the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= 16'd0;
      r_col  <= 16'd0;
      r_addr <= 16'd0;
      r_fin  <= 1'b0;
    end else if (i_clr) begin
      r_row  <= 16'd0;
      r_col  <= 16'd0;
      r_addr <= 16'd0;
      r_fin  <= 1'b0;
    end else if (w_issue) begin
      if (w_at_end) begin
        r_fin <= 1'b1;
      end else if (r_col == LAST_COL) begin
        r_col <= 16'd0;
        r_row <= r_row + 16'd1;
      end else begin
        r_col <= r_col + 16'd1;
      end
      // Pixel address saturates on the final pixel rather than wrapping.
      if (!w_border && (r_addr != LAST_ADDR)) begin
        r_addr <= r_addr + 16'd1;
      end
    end
  end

  assign o_issue  = w_issue;
  assign o_border = w_border;
  assign o_last   = w_issue & w_at_end;
  assign o_addr   = r_addr;

endmodule

// File: rtl/conv_feeder.sv
// Convolution feeder: loads serial kernel weights, then streams the feature map to the engine.
// Optional zero-border padding is enabled with the CONV_FEEDER_PAD_EN macro.
module conv_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int DW    = DEF_DW
) (
  input  logic            clk,
  input  logic            rst,
  conv_feeder_if.master   bus
);

  state_t          r_state;
  state_t          w_next;
  logic            w_job_done;
  logic            w_clr;
  logic            r_mode;
  logic [WV_W-1:0] r_wvec;
  logic [6:0]      r_wcnt;

  logic            w_issue;
  logic            w_border;
  logic            w_last;
  logic [15:0]     w_addr;
  logic            w_rd_en;

  logic            r_v1;
  logic            r_b1;
  logic            r_l1;
  logic            r_start;
  logic            r_l2;
  logic [DW-1:0]   r_din;

  assign w_clr = (r_state == ST_IDLE) && bus.go;

  conv_feeder_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_clr),
    .i_en     (r_state == ST_STREAM),
    .o_issue  (w_issue),
    .o_border (w_border),
    .o_last   (w_last),
    .o_addr   (w_addr)
  );

  // Next-state decision; STREAM is left only once the final sample is on conv_din.
  always_comb begin
    w_next     = r_state;
    w_job_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.go) w_next = ST_LOAD_W;
        else        w_next = ST_IDLE;
      end
      ST_LOAD_W: begin
        if (r_wcnt == last_wbit(r_mode)) w_next = ST_STREAM;
        else                             w_next = ST_LOAD_W;
      end
      ST_STREAM: begin
        if (r_l2) w_next = ST_DRAIN;
        else      w_next = ST_STREAM;
      end
      ST_DRAIN: begin
        if (bus.conv_done) begin
          w_next     = ST_IDLE;
          w_job_done = 1'b1;
        end else begin
          w_next     = ST_DRAIN;
        end
      end
      default: begin
        w_next     = ST_IDLE;
        w_job_done = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Job latches and the serial weight bit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= 1'b0;
      r_wvec <= {WV_W{1'b0}};
      r_wcnt <= 7'd0;
    end else if (w_clr) begin
      r_mode <= bus.mode;
      r_wvec <= bus.wvec;
      r_wcnt <= 7'd0;
    end else if (r_state == ST_LOAD_W) begin
      r_wcnt <= r_wcnt + 7'd1;
    end
  end

  // Two-stage read pipeline: rd_data is valid one cycle after rd_en and is then registered out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_b1    <= 1'b0;
      r_l1    <= 1'b0;
      r_start <= 1'b0;
      r_l2    <= 1'b0;
      r_din   <= {DW{1'b0}};
    end else begin
      r_v1    <= w_issue;
      r_b1    <= w_border;
      r_l1    <= w_last;
      r_start <= r_v1;
      r_l2    <= r_l1;
      r_din   <= (r_v1 && !r_b1) ? bus.rd_data : {DW{1'b0}};
    end
  end

  assign w_rd_en            = w_issue & ~w_border;
  assign bus.rd_en          = w_rd_en;
  assign bus.rd_addr        = w_rd_en ? w_addr : 16'd0;
  assign bus.conv_start     = r_start;
  assign bus.conv_din       = r_din;
  assign bus.conv_state     = r_mode;
  assign bus.conv_weight_en = (r_state == ST_LOAD_W);
  assign bus.conv_weight    = (r_state == ST_LOAD_W) & r_wvec[r_wcnt];
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.job_done       = w_job_done;

endmodule

// File: tb/tb_conv_feeder.sv
// Directed-plus-random bench for conv_feeder on a 4x4 map; padded geometry follows CONV_FEEDER_PAD_EN.
// Expected weights and samples come from a queue-based model of the map walk.
module tb_conv_feeder;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 16;
  localparam int N  = W * H;
`ifdef CONV_FEEDER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif
  localparam int COLS = PAD ? W + 2 : W;
  localparam int ROWS = PAD ? H + 2 : H;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [DW-1:0] mem [N];

  conv_feeder_if #(.DW(DW)) bus ();

  conv_feeder #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feature buffer: registered read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en && (bus.rd_addr < 16'(N))) bus.rd_data <= mem[bus.rd_addr];
    else                                     bus.rd_data <= 16'hBAD0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd_en"}, bus.rd_en, 0);
    check({tag, "_rd_addr"}, bus.rd_addr, 0);
    check({tag, "_start"}, bus.conv_start, 0);
    check({tag, "_din"}, bus.conv_din, 0);
    check({tag, "_state"}, bus.conv_state, 0);
    check({tag, "_wen"}, bus.conv_weight_en, 0);
    check({tag, "_wbit"}, bus.conv_weight, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_jdone"}, bus.job_done, 0);
  endtask

  // One job from go to return-to-IDLE, or until rst is applied after sample rst_at.
  task automatic do_job(input bit m, input logic [89:0] w, input bit done_in_stream,
                        input int done_dly, input bit go_with_done, input int rst_at);
    logic [15:0] exp_s[$];
    bit          exp_b[$];
    int          rdq[$];
    int          nw, ns, pix, wcnt, wlast, rdcnt, scnt, drain_c, done_c;
    bit          brd, exp_jd, stream_pulsed;
    nw = m ? 90 : 9;
    pix = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        brd = PAD && (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1);
        exp_b.push_back(brd);
        exp_s.push_back(brd ? 16'd0 : mem[pix]);
        if (!brd) pix++;
      end
    end
    ns = exp_s.size();
    wcnt = 0; wlast = -1; rdcnt = 0; scnt = 0; drain_c = -1; done_c = -1;
    stream_pulsed = 1'b0;

    @(negedge clk);
    bus.go = 1'b1; bus.mode = m; bus.wvec = w; bus.conv_done = 1'b0;
    #1;
    check("idle_busy", bus.busy, 0);
    check("idle_wen", bus.conv_weight_en, 0);

    for (int cyc = 1; cyc < 400; cyc++) begin
      @(negedge clk);
      bus.go = 1'b0; bus.mode = ~m; bus.wvec = ~w; bus.conv_done = 1'b0;
      exp_jd = 1'b0;
      if (done_in_stream && !stream_pulsed && scnt == 3) begin
        bus.conv_done = 1'b1;
        stream_pulsed = 1'b1;
      end
      if (drain_c >= 0 && cyc == drain_c + done_dly) begin
        bus.conv_done = 1'b1;
        bus.go = go_with_done;
        exp_jd = 1'b1;
      end
      #1;
      if (bus.conv_weight_en) begin
        if (wcnt == 0) check("w_first", cyc, 1);
        if (wcnt < nw) check("wbit", bus.conv_weight, w[wcnt]);
        wlast = cyc;
        wcnt++;
      end
      if (bus.rd_en) begin
        check("rd_addr", bus.rd_addr, rdcnt);
        if (rdcnt == 0) check("rd_first", cyc, wlast + 1 + (PAD ? COLS + 1 : 0));
        rdq.push_back(cyc);
        rdcnt++;
      end
      if (bus.conv_start) begin
        if (scnt < ns) begin
          check("din", bus.conv_din, exp_s[scnt]);
          check("s_time", cyc, wlast + 3 + scnt);
          if (!exp_b[scnt] && rdq.size() > 0) check("rd2din", cyc, rdq.pop_front() + 2);
        end
        scnt++;
        if (rst_at >= 0 && scnt == rst_at + 1) begin
          bus.conv_done = 1'b0;
          rst = 1'b1;
          #1;
          check_zero("rst_mid");
          @(negedge clk);
          check_zero("rst_hold");
          rst = 1'b0;
          return;
        end
      end else begin
        check("din_idle", bus.conv_din, 0);
      end
      if (bus.busy) check("cstate", bus.conv_state, m);
      check("job_done", bus.job_done, exp_jd);
      if (exp_jd) done_c = cyc;
      if (drain_c < 0 && scnt >= ns && !bus.conv_start) begin
        drain_c = cyc;
        check("drain_busy", bus.busy, 1);
      end
      if (done_c >= 0 && cyc == done_c + 1) begin
        check("idle_after", bus.busy, 0);
        check("state_hold", bus.conv_state, m);
        check("wen_after", bus.conv_weight_en, 0);
        break;
      end
    end
    check("done_seen", done_c >= 0, 1);
    check("wcount", wcnt, nw);
    check("rdcount", rdcnt, N);
    check("scount", scnt, ns);
  endtask

  task automatic fill_random();
    for (int a = 0; a < N; a++) mem[a] = 16'($urandom());
  endtask

  function automatic logic [89:0] rand_w();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[89:0];
  endfunction

  initial begin
    logic [89:0] w;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.go = 1'b0; bus.mode = 1'b0; bus.wvec = 90'd0; bus.conv_done = 1'b0;
    fill_random();
    repeat (2) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("post_reset");

    // Mode 0 with the reference kernel pattern in the low bits.
    w = rand_w();
    w[8:0] = 9'b101100111;
    do_job(1'b0, w, 1'b0, 2, 1'b0, -1);

    // Mode 1, buffer holds its own address, conv_done in STREAM then 5 cycles into DRAIN.
    for (int a = 0; a < N; a++) mem[a] = 16'(a);
    do_job(1'b1, rand_w(), 1'b1, 5, 1'b0, -1);

    // go coincident with conv_done in DRAIN is dropped.
    fill_random();
    do_job(1'b0, rand_w(), 1'b0, 1, 1'b1, -1);

    // Reset at sample 7, then a fresh job must restart cleanly.
    do_job(1'b1, rand_w(), 1'b0, 3, 1'b0, 7);
    fill_random();
    do_job(1'b0, rand_w(), 1'b0, 4, 1'b0, -1);
    do_job(1'b1, rand_w(), 1'b1, 2, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
CONV_FEEDER -- requirements
Module: conv_feeder

Interface
REQ-001 SHALL have parameter IMG_W, default 28, which sets the feature-map width in pixels.
REQ-002 SHALL have parameter IMG_H, default 28, which sets the feature-map height in pixels.
REQ-003 SHALL have parameter DW, default 16, which sets the signed pixel width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port go, input, 1 bit: job-start pulse.
REQ-007 SHALL have port mode, input, 1 bit: 0 selects single kernel (9 weight bits); 1 selects ten kernels (90 weight bits).
REQ-008 SHALL have port wvec, input, 90 bits: packed binary weights; mode 0 uses only bits [8:0].
REQ-009 SHALL have port rd_en, output, 1 bit: feature-buffer read strobe.
REQ-010 SHALL have port rd_addr, output, 16 bits: pixel address, row-major.
REQ-011 SHALL have port rd_data, input, DW bits: read data, valid exactly 1 cycle after rd_en.
REQ-012 SHALL have port conv_start, output, 1 bit: stream-valid to the convolution engine.
REQ-013 SHALL have port conv_din, output, DW bits: signed pixel to the engine.
REQ-014 SHALL have port conv_state, output, 1 bit: the latched mode.
REQ-015 SHALL have port conv_weight_en, output, 1 bit: weight-bit valid.
REQ-016 SHALL have port conv_weight, output, 1 bit: serial weight bit.
REQ-017 SHALL have port conv_done, input, 1 bit: engine completion pulse.
REQ-018 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-019 SHALL have port job_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-020 FSM SHALL have states IDLE, LOAD_W, STREAM and DRAIN; the next-state decision is registered.
REQ-021 In IDLE, go=1 SHALL latch mode and wvec and enter LOAD_W; go in any other state SHALL be ignored.
REQ-022 LOAD_W SHALL hold conv_weight_en=1 for exactly NW consecutive cycles (NW=9 for mode 0, 90 for mode 1), presenting wvec bit 0 first, ascending; it SHALL then enter STREAM on the next cycle.
REQ-023 STREAM SHALL issue rd_en with rd_addr=0..IMG_W*IMG_H-1 on consecutive cycles, one address per cycle, with no gaps.
REQ-024 The data for the address issued in cycle t SHALL appear registered on conv_din with conv_start=1 in cycle t+2 (rd_data is captured into a register at t+1).
REQ-025 conv_start SHALL be continuous for exactly IMG_W*IMG_H cycles per job; when it is not asserted, conv_din SHALL be 0.
REQ-026 After the last sample leaves, the FSM SHALL enter DRAIN; conv_done in DRAIN SHALL return the FSM to IDLE, with job_done=1 in that same transition cycle.
REQ-027 conv_done in IDLE, LOAD_W or STREAM SHALL be ignored.
REQ-028 conv_state SHALL equal the latched mode from LOAD_W entry until the return to IDLE, and SHALL hold its value while in IDLE.
REQ-029 The address counter SHALL saturate at IMG_W*IMG_H-1 and SHALL never wrap within a job.
REQ-030 go and conv_done asserted in the same cycle while in DRAIN SHALL complete the current job only; that go SHALL be dropped.

Reset
REQ-031 rst SHALL asynchronously force IDLE and clear all counters and latches, with every output at 0, including mid-job; no partial job SHALL resume after rst deasserts.

Configuration
REQ-032 With macro CONV_FEEDER_PAD_EN defined, STREAM SHALL emit (IMG_W+2)*(IMG_H+2) samples, with zeros on the 1-pixel border; rd_en SHALL be low for border positions and interior order SHALL be unchanged.
REQ-033 Without CONV_FEEDER_PAD_EN, the behaviour SHALL be exactly as in REQ-023..REQ-025, and no pad logic SHALL be synthesised.

Structure
REQ-034 Shared package conv_pkg SHALL hold the FSM state encodings, NW0=9, NW1=90 and the default DW.
REQ-035 Row/column/address generation, including pad detection, SHALL live in one sub-module conv_feeder_addr_gen.

Verification
REQ-036 Scenario: mode 0, wvec[8:0]=9'b101100111, go -> conv_weight_en high for 9 cycles carrying bits 1,1,1,0,0,1,1,0,1, then STREAM.
REQ-037 Scenario: mode 1, IMG_W=IMG_H=4, buffer data = address -> 90 weight cycles, then conv_din 0..15 with conv_start high for exactly 16 cycles, 2 cycles after each rd_en.
REQ-038 Scenario: conv_done pulsed during STREAM, then again 5 cycles after DRAIN entry -> first pulse ignored; job_done pulses once, on the second.
REQ-039 Scenario: rst asserted at sample 7 of 16 -> all outputs 0 immediately; a new go afterwards restarts from weight bit 0 and address 0.
REQ-040 Scenario: CONV_FEEDER_PAD_EN with a 4x4 map -> 36 samples; the first 7 are zero; sample 7 equals pixel 0; rd_en is issued exactly 16 times.
